// File: rtl/lnrv_icb_arbt_mux_if.sv
// rtl/lnrv_icb_arbt_mux_if.sv - ICB bus bundle carrying P_PORTS packed lanes
//
// Purpose: bundles the command and response channels of one or more ICB
// ports. Per-lane fields are packed side by side, with lane i occupying
// bits [i*W +: W] of each field.
//
// Modports:
//   master - drives cmd_vld/write/addr/wdata/wstrb/size and rsp_rdy;
//            receives cmd_rdy and rsp_vld/rdata/err.
//   slave  - the mirror image of master.
interface lnrv_icb_arbt_mux_if #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_PORTS      = 1
);
  localparam int LP_STRB_W = P_DATA_WIDTH / 8;

  logic [P_PORTS-1:0]              icb_cmd_vld;
  logic [P_PORTS-1:0]              icb_cmd_rdy;
  logic [P_PORTS-1:0]              icb_cmd_write;
  logic [P_ADDR_WIDTH*P_PORTS-1:0] icb_cmd_addr;
  logic [P_DATA_WIDTH*P_PORTS-1:0] icb_cmd_wdata;
  logic [LP_STRB_W*P_PORTS-1:0]    icb_cmd_wstrb;
  logic [3*P_PORTS-1:0]            icb_cmd_size;
  logic [P_PORTS-1:0]              icb_rsp_vld;
  logic [P_PORTS-1:0]              icb_rsp_rdy;
  logic [P_DATA_WIDTH*P_PORTS-1:0] icb_rsp_rdata;
  logic [P_PORTS-1:0]              icb_rsp_err;

  modport master (
    output icb_cmd_vld, icb_cmd_write, icb_cmd_addr, icb_cmd_wdata,
           icb_cmd_wstrb, icb_cmd_size, icb_rsp_rdy,
    input  icb_cmd_rdy, icb_rsp_vld, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_vld, icb_cmd_write, icb_cmd_addr, icb_cmd_wdata,
           icb_cmd_wstrb, icb_cmd_size, icb_rsp_rdy,
    output icb_cmd_rdy, icb_rsp_vld, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/lnrv_icb_arbt_mux.sv
// rtl/lnrv_icb_arbt_mux.sv - N-master to 1-slave ICB multiplexer with arbitration
//
// Purpose: arbitrates P_ICB_COUNT ICB masters onto one ICB slave using
// either fixed priority (lowest index wins) or round-robin. A routing FIFO
// of depth P_OTS_COUNT remembers which master issued each accepted command
// so responses, which the slave returns in command order, go back to the
// right master. Command and response paths are purely combinational.
//
// Ports:
//   clk, reset - clock; asynchronous active-high reset
//   mn         - P_ICB_COUNT master-facing ports (this block is their slave)
//   s          - single slave-facing port (this block is its master)
//   ots_cnt    - number of commands currently outstanding
//   rsp_unexp  - sticky: slave presented a response with nothing outstanding
module lnrv_icb_arbt_mux #(
  parameter int    P_ADDR_WIDTH = 32,
  parameter int    P_DATA_WIDTH = 32,
  parameter int    P_ICB_COUNT  = 4,
  parameter int    P_OTS_COUNT  = 2,
  parameter string P_ARBT_TYPE  = "round-robin",
  localparam int   LP_ID_W      = (P_ICB_COUNT > 1) ? $clog2(P_ICB_COUNT) : 1,
  localparam int   LP_CNT_W     = $clog2(P_OTS_COUNT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  lnrv_icb_arbt_mux_if.slave  mn,
  lnrv_icb_arbt_mux_if.master s,
  output logic [LP_CNT_W-1:0] ots_cnt,
  output logic                rsp_unexp
);

  localparam int LP_STRB_W = P_DATA_WIDTH / 8;
  localparam int LP_PTR_W  = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
  localparam bit LP_FIXED  = (P_ARBT_TYPE == "fixed");

  logic [P_ICB_COUNT-1:0] req;
  logic                   full;
  logic                   empty;

  logic                   gnt_vld;
  logic [LP_ID_W-1:0]     gnt_id;
  logic [LP_ID_W-1:0]     rr_cand;
  logic [P_ICB_COUNT-1:0] gnt_oh;
  logic                   gnt_mvld;

  logic                   lock_vld;
  logic [LP_ID_W-1:0]     lock_id;
  logic [LP_ID_W-1:0]     rr_ptr;

  logic [LP_ID_W-1:0]     route_mem [P_OTS_COUNT];
  logic [LP_PTR_W-1:0]    wr_ptr;
  logic [LP_PTR_W-1:0]    rd_ptr;
  logic [LP_ID_W-1:0]     head_id;

  logic                   s_cmd_vld;
  logic                   s_rsp_rdy;
  logic                   cmd_hs;
  logic                   rsp_hs;

  function automatic logic [LP_ID_W-1:0] id_inc(input logic [LP_ID_W-1:0] v);
    if (v == LP_ID_W'(P_ICB_COUNT - 1)) return '0;
    return v + 1'b1;
  endfunction

  function automatic logic [LP_PTR_W-1:0] ptr_inc(input logic [LP_PTR_W-1:0] p);
    if (p == LP_PTR_W'(P_OTS_COUNT - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Reset is folded in so that every handshake output reads 0 while reset is
  // held, even if masters keep their vld asserted.
  assign full  = (ots_cnt == LP_CNT_W'(P_OTS_COUNT));
  assign empty = (ots_cnt == '0);
  assign req   = mn.icb_cmd_vld & {P_ICB_COUNT{~full & ~reset}};

  // Arbitration. A stalled grant is held through lock_vld so the slave sees
  // a stable command until it is accepted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    rr_cand = '0;
    if (lock_vld) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id;
    end else if (LP_FIXED) begin
      for (int i = P_ICB_COUNT - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_vld = 1'b1;
          gnt_id  = LP_ID_W'(i);
        end
      end
    end else begin
      // Scan from the farthest candidate back to rr_ptr; the last hit,
      // i.e. the first requester at or after rr_ptr, wins.
      for (int k = P_ICB_COUNT - 1; k >= 0; k--) begin
        rr_cand = LP_ID_W'((int'(rr_ptr) + k) % P_ICB_COUNT);
        if (req[rr_cand]) begin
          gnt_vld = 1'b1;
          gnt_id  = rr_cand;
        end
      end
    end
  end

  // Command mux: fields come from the granted master, zero without a grant.
  always_comb begin
    gnt_oh          = '0;
    gnt_mvld        = 1'b0;
    s.icb_cmd_write = 1'b0;
    s.icb_cmd_addr  = '0;
    s.icb_cmd_wdata = '0;
    s.icb_cmd_wstrb = '0;
    s.icb_cmd_size  = '0;
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      if (gnt_vld && (gnt_id == LP_ID_W'(i))) begin
        gnt_oh[i]       = 1'b1;
        gnt_mvld        = mn.icb_cmd_vld[i];
        s.icb_cmd_write = mn.icb_cmd_write[i];
        s.icb_cmd_addr  = mn.icb_cmd_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        s.icb_cmd_wdata = mn.icb_cmd_wdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        s.icb_cmd_wstrb = mn.icb_cmd_wstrb[i*LP_STRB_W +: LP_STRB_W];
        s.icb_cmd_size  = mn.icb_cmd_size[i*3 +: 3];
      end
    end
  end

  assign s_cmd_vld      = |(gnt_oh & req);
  assign s.icb_cmd_vld  = s_cmd_vld;
  assign mn.icb_cmd_rdy = gnt_oh & {P_ICB_COUNT{~full & s.icb_cmd_rdy}};
  assign cmd_hs         = s_cmd_vld & s.icb_cmd_rdy;

  // Response demux: only the master at the FIFO head sees the response.
  assign head_id = route_mem[rd_ptr];

  always_comb begin
    mn.icb_rsp_vld   = '0;
    mn.icb_rsp_rdata = '0;
    mn.icb_rsp_err   = '0;
    s_rsp_rdy        = 1'b0;
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      if (!empty && (head_id == LP_ID_W'(i))) begin
        mn.icb_rsp_vld[i]                            = s.icb_rsp_vld;
        mn.icb_rsp_rdata[i*P_DATA_WIDTH +: P_DATA_WIDTH] = s.icb_rsp_rdata;
        mn.icb_rsp_err[i]                            = s.icb_rsp_err;
        s_rsp_rdy                                    = mn.icb_rsp_rdy[i];
      end
    end
  end

  assign s.icb_rsp_rdy = s_rsp_rdy;
  assign rsp_hs        = s.icb_rsp_vld & s_rsp_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ots_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rr_ptr    <= '0;
      lock_vld  <= 1'b0;
      lock_id   <= '0;
      rsp_unexp <= 1'b0;
    end else begin
      // Lock follows the granted master's own vld, so a master that drops
      // vld while stalled releases the lock one cycle later.
      lock_vld <= gnt_vld & gnt_mvld & ~s.icb_cmd_rdy;
      lock_id  <= gnt_id;

      if (cmd_hs) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rr_ptr <= id_inc(gnt_id);
      end
      if (rsp_hs) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      if (cmd_hs && !rsp_hs) begin
        ots_cnt <= ots_cnt + 1'b1;
      end else if (!cmd_hs && rsp_hs) begin
        ots_cnt <= ots_cnt - 1'b1;
      end

      if (s.icb_rsp_vld && empty) begin
        rsp_unexp <= 1'b1;
      end
    end
  end

  // Routing storage needs no reset: entries are only read below wr_ptr.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      route_mem[wr_ptr] <= gnt_id;
    end
  end

endmodule

// File: tb/tb_lnrv_icb_arbt_mux.sv
// tb/tb_lnrv_icb_arbt_mux.sv - randomized bench for lnrv_icb_arbt_mux, round-robin and fixed
module tb_lnrv_icb_arbt_mux;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int OTS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus, index 0 = round-robin DUT, index 1 = fixed-priority DUT.
  logic [N-1:0]    m_vld       [2];
  logic [N-1:0]    m_write     [2];
  logic [N-1:0]    m_rsp_rdy   [2];
  logic [N-1:0]    hs_mask     [2];
  logic [AW*N-1:0] m_addr      [2];
  logic [DW*N-1:0] m_wdata     [2];
  logic [SW*N-1:0] m_wstrb     [2];
  logic [3*N-1:0]  m_size      [2];
  logic            s_cmd_rdy   [2];
  logic            s_rsp_vld   [2];
  logic            s_rsp_err   [2];
  logic [DW-1:0]   s_rsp_rdata [2];

  logic [N-1:0]    o_cmd_rdy   [2];
  logic [N-1:0]    o_rsp_vld   [2];
  logic [N-1:0]    o_rsp_err   [2];
  logic [DW*N-1:0] o_rsp_rdata [2];
  logic            o_s_vld     [2];
  logic            o_s_write   [2];
  logic [AW-1:0]   o_s_addr    [2];
  logic [DW-1:0]   o_s_wdata   [2];
  logic [SW-1:0]   o_s_wstrb   [2];
  logic [2:0]      o_s_size    [2];
  logic            o_s_rsp_rdy [2];
  logic [1:0]      o_ots       [2];
  logic            o_unexp     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lnrv_icb_arbt_mux_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_PORTS(N)) mif ();
    lnrv_icb_arbt_mux_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_PORTS(1)) sif ();

    assign mif.icb_cmd_vld   = m_vld[g];
    assign mif.icb_cmd_write = m_write[g];
    assign mif.icb_cmd_addr  = m_addr[g];
    assign mif.icb_cmd_wdata = m_wdata[g];
    assign mif.icb_cmd_wstrb = m_wstrb[g];
    assign mif.icb_cmd_size  = m_size[g];
    assign mif.icb_rsp_rdy   = m_rsp_rdy[g];
    assign sif.icb_cmd_rdy   = s_cmd_rdy[g];
    assign sif.icb_rsp_vld   = s_rsp_vld[g];
    assign sif.icb_rsp_rdata = s_rsp_rdata[g];
    assign sif.icb_rsp_err   = s_rsp_err[g];

    assign o_cmd_rdy[g]   = mif.icb_cmd_rdy;
    assign o_rsp_vld[g]   = mif.icb_rsp_vld;
    assign o_rsp_err[g]   = mif.icb_rsp_err;
    assign o_rsp_rdata[g] = mif.icb_rsp_rdata;
    assign o_s_vld[g]     = sif.icb_cmd_vld;
    assign o_s_write[g]   = sif.icb_cmd_write;
    assign o_s_addr[g]    = sif.icb_cmd_addr;
    assign o_s_wdata[g]   = sif.icb_cmd_wdata;
    assign o_s_wstrb[g]   = sif.icb_cmd_wstrb;
    assign o_s_size[g]    = sif.icb_cmd_size;
    assign o_s_rsp_rdy[g] = sif.icb_rsp_rdy;

    if (g == 0) begin : g_rr
      lnrv_icb_arbt_mux #(
        .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ICB_COUNT(N),
        .P_OTS_COUNT(OTS), .P_ARBT_TYPE("round-robin")
      ) u_dut (
        .clk(clk), .reset(rst), .mn(mif), .s(sif),
        .ots_cnt(o_ots[g]), .rsp_unexp(o_unexp[g])
      );
    end else begin : g_fx
      lnrv_icb_arbt_mux #(
        .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ICB_COUNT(N),
        .P_OTS_COUNT(OTS), .P_ARBT_TYPE("fixed")
      ) u_dut (
        .clk(clk), .reset(rst), .mn(mif), .s(sif),
        .ots_cnt(o_ots[g]), .rsp_unexp(o_unexp[g])
      );
    end
  end

  // Reference model state: queue of issuing masters, queue of issued
  // addresses (echoed back by the slave as rdata), grant lock and pointer.
  int            route_q [2][$];
  logic [AW-1:0] addr_q  [2][$];
  bit            lock_v  [2];
  int            lock_i  [2];
  int            rr      [2];
  bit            unexp_m [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      route_q[d].delete();
      addr_q[d].delete();
      lock_v[d]  = 1'b0;
      lock_i[d]  = 0;
      rr[d]      = 0;
      unexp_m[d] = 1'b0;
    end
  endtask

  task automatic check_reset(input int d);
    check_val($sformatf("dut%0d rst cmd_rdy", d), 128'(o_cmd_rdy[d]), 128'(0));
    check_val($sformatf("dut%0d rst rsp_vld", d), 128'(o_rsp_vld[d]), 128'(0));
    check_val($sformatf("dut%0d rst s_cmd_vld", d), 128'(o_s_vld[d]), 128'(0));
    check_val($sformatf("dut%0d rst s_rsp_rdy", d), 128'(o_s_rsp_rdy[d]), 128'(0));
    check_val($sformatf("dut%0d rst ots_cnt", d), 128'(o_ots[d]), 128'(0));
    check_val($sformatf("dut%0d rst rsp_unexp", d), 128'(o_unexp[d]), 128'(0));
  endtask

  // Masters hold vld and payload until handshake; slave echoes addresses.
  task automatic drive(input int d, input int p_vld, input int p_srdy, input int p_rsp, input bit allow_unexp);
    m_vld[d]   = m_vld[d] & ~hs_mask[d];
    hs_mask[d] = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_vld[d][i] && ($urandom_range(99) < p_vld)) begin
        m_vld[d][i]               = 1'b1;
        m_write[d][i]             = 1'($urandom_range(1));
        m_addr[d][i*AW +: AW]     = $urandom;
        m_wdata[d][i*DW +: DW]    = $urandom;
        m_wstrb[d][i*SW +: SW]    = SW'($urandom);
        m_size[d][i*3 +: 3]       = 3'($urandom);
      end
    end
    m_rsp_rdy[d]   = N'($urandom);
    s_cmd_rdy[d]   = ($urandom_range(99) < p_srdy);
    s_rsp_vld[d]   = ((route_q[d].size() != 0) || allow_unexp) && ($urandom_range(99) < p_rsp);
    s_rsp_rdata[d] = (addr_q[d].size() != 0) ? addr_q[d][0] : $urandom;
    s_rsp_err[d]   = 1'($urandom_range(1));
  endtask

  task automatic model_cycle(input int d);
    logic [N-1:0]    req, e_cmd_rdy, e_rsp_vld, e_rsp_err;
    logic [DW*N-1:0] e_rdata;
    logic [71:0]     e_fields, o_fields;
    bit full, empty, gv, e_svld, e_srdy, fixed;
    int gid, head, idx;
    fixed = (d == 1);
    full  = (route_q[d].size() == OTS);
    empty = (route_q[d].size() == 0);
    req   = full ? '0 : m_vld[d];
    gv    = 1'b0;
    gid   = 0;
    if (lock_v[d]) begin
      gv  = 1'b1;
      gid = lock_i[d];
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = fixed ? k : (rr[d] + k) % N;
        if (!gv && req[idx]) begin
          gv  = 1'b1;
          gid = idx;
        end
      end
    end
    e_fields  = gv ? {m_write[d][gid], m_addr[d][gid*AW +: AW], m_wdata[d][gid*DW +: DW],
                      m_wstrb[d][gid*SW +: SW], m_size[d][gid*3 +: 3]} : 72'd0;
    o_fields  = {o_s_write[d], o_s_addr[d], o_s_wdata[d], o_s_wstrb[d], o_s_size[d]};
    e_svld    = gv && req[gid];
    e_cmd_rdy = (gv && !full && s_cmd_rdy[d]) ? (N'(1) << gid) : '0;
    head      = empty ? 0 : route_q[d][0];
    e_rsp_vld = (!empty && s_rsp_vld[d]) ? (N'(1) << head) : '0;
    e_rsp_err = (!empty && s_rsp_err[d]) ? (N'(1) << head) : '0;
    e_rdata   = '0;
    if (!empty) e_rdata[head*DW +: DW] = s_rsp_rdata[d];
    e_srdy    = !empty && m_rsp_rdy[d][head];

    check_val($sformatf("dut%0d s_cmd_vld", d), 128'(o_s_vld[d]), 128'(e_svld));
    check_val($sformatf("dut%0d s_cmd_fields", d), 128'(o_fields), 128'(e_fields));
    check_val($sformatf("dut%0d m_cmd_rdy", d), 128'(o_cmd_rdy[d]), 128'(e_cmd_rdy));
    check_val($sformatf("dut%0d m_rsp_vld", d), 128'(o_rsp_vld[d]), 128'(e_rsp_vld));
    check_val($sformatf("dut%0d m_rsp_rdata", d), 128'(o_rsp_rdata[d]), 128'(e_rdata));
    check_val($sformatf("dut%0d m_rsp_err", d), 128'(o_rsp_err[d]), 128'(e_rsp_err));
    check_val($sformatf("dut%0d s_rsp_rdy", d), 128'(o_s_rsp_rdy[d]), 128'(e_srdy));
    check_val($sformatf("dut%0d ots_cnt", d), 128'(o_ots[d]), 128'(route_q[d].size()));
    check_val($sformatf("dut%0d rsp_unexp", d), 128'(o_unexp[d]), 128'(unexp_m[d]));

    // Advance the model to the state after the coming clock edge.
    lock_v[d] = gv && m_vld[d][gid] && !s_cmd_rdy[d];
    lock_i[d] = gid;
    if (s_rsp_vld[d] && empty) unexp_m[d] = 1'b1;
    if (s_rsp_vld[d] && e_srdy) begin
      void'(route_q[d].pop_front());
      void'(addr_q[d].pop_front());
    end
    if (e_svld && s_cmd_rdy[d]) begin
      route_q[d].push_back(gid);
      addr_q[d].push_back(m_addr[d][gid*AW +: AW]);
      rr[d]      = (gid + 1) % N;
      hs_mask[d] = N'(1) << gid;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic run_phase(input int cycles, input int p_vld, input int p_srdy, input int p_rsp, input bit allow_unexp);
    for (int c = 0; c < cycles; c++) begin
      for (int d = 0; d < 2; d++) drive(d, p_vld, p_srdy, p_rsp, allow_unexp);
      #1;
      for (int d = 0; d < 2; d++) model_cycle(d);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_vld[d]       = '1;
      m_write[d]     = '0;
      m_addr[d]      = '0;
      m_wdata[d]     = '0;
      m_wstrb[d]     = '0;
      m_size[d]      = '0;
      m_rsp_rdy[d]   = '1;
      hs_mask[d]     = '0;
      s_cmd_rdy[d]   = 1'b1;
      s_rsp_vld[d]   = 1'b1;
      s_rsp_err[d]   = 1'b0;
      s_rsp_rdata[d] = '0;
    end
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) check_reset(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) s_rsp_vld[d] = 1'b0;
    rst = 1'b0;

    run_phase(200, 100, 100, 100, 1'b0);   // saturated traffic, no backpressure
    run_phase(1000, 50, 50, 50, 1'b0);     // mixed traffic
    run_phase(600, 60, 30, 15, 1'b0);      // heavy stalls: locks and full FIFO
    run_phase(40, 0, 100, 100, 1'b0);      // drain
    run_phase(10, 0, 100, 100, 1'b1);      // responses with nothing outstanding
    run_phase(60, 70, 60, 40, 1'b0);       // rebuild outstanding traffic

    // Reset in the middle of a busy cycle, after the modelled edge.
    for (int d = 0; d < 2; d++) drive(d, 100, 100, 100, 1'b1);
    #1;
    for (int d = 0; d < 2; d++) model_cycle(d);
    #6;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_reset(d);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_phase(300, 50, 50, 50, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
